// File: rtl/reg_file_onehot_wr_if.sv
// Write/read bus of the one-hot-write register file: write-back decoder
// drives the write side, ID-stage operand fetch uses the read side.
interface reg_file_onehot_wr_if #(
    parameter int N = 32,
    parameter int W = 32
);
    logic [N-1:0]         i_WE;
    logic [W-1:0]         i_D;
    logic [$clog2(N)-1:0] i_RA1;
    logic [$clog2(N)-1:0] i_RA2;
    logic [W-1:0]         o_RD1;
    logic [W-1:0]         o_RD2;
    logic                 o_MultiHot;
    logic [$clog2(N)-1:0] o_LastWrA;
    logic                 o_WrValid;

    modport master (
        output i_WE, i_D, i_RA1, i_RA2,
        input  o_RD1, o_RD2, o_MultiHot, o_LastWrA, o_WrValid
    );

    modport slave (
        input  i_WE, i_D, i_RA1, i_RA2,
        output o_RD1, o_RD2, o_MultiHot, o_LastWrA, o_WrValid
    );
endinterface

// File: rtl/reg_file_onehot_wr.sv
// N x W register file with one-hot write enable, reg 0 hardwired to zero,
// sticky multi-hot error flag. Define REGFILE_BYPASS_EN for write-before-read bypass.
module reg_file_onehot_wr #(
    parameter int N = 32,
    parameter int W = 32
) (
    input logic                 i_CLK,
    input logic                 i_RST_N,
    reg_file_onehot_wr_if.slave bus
);
    localparam int AW = $clog2(N);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [W-1:0]  regs_q [N];
    logic [W-1:0]  regs_d [N];
    logic          multi_hot_q, multi_hot_d;
    logic [AW-1:0] last_wr_a_q, last_wr_a_d;
    logic          wr_valid_q, wr_valid_d;

    logic          we_single;
    logic          we_multi;
    logic [AW-1:0] wr_idx;
    logic          wr_commit;

    function automatic logic [AW-1:0] encode(input logic [N-1:0] v);
        logic [AW-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) idx = i[AW-1:0];
        end
        return idx;
    endfunction

    function automatic logic [W-1:0] read_port(input logic [AW-1:0] addr);
        logic [W-1:0] val;
        val = regs_q[addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_commit && (wr_idx == addr)) val = bus.i_D;
`endif
        if (addr == '0) val = '0;
        return val;
    endfunction

    // Power-of-two test: exactly one bit set iff nonzero and v & (v-1) == 0.
    always_comb begin
        we_single = (bus.i_WE != '0) && ((bus.i_WE & (bus.i_WE - ONE)) == '0);
        we_multi  = (bus.i_WE != '0) && !we_single;
        wr_idx    = encode(bus.i_WE);
        wr_commit = we_single && (wr_idx != '0);
    end

    always_comb begin
        regs_d      = regs_q;
        multi_hot_d = multi_hot_q | we_multi;
        last_wr_a_d = last_wr_a_q;
        wr_valid_d  = wr_commit;
        if (wr_commit) begin
            regs_d[wr_idx] = bus.i_D;
            last_wr_a_d    = wr_idx;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            for (int i = 0; i < N; i++) regs_q[i] <= '0;
            multi_hot_q <= 1'b0;
            last_wr_a_q <= '0;
            wr_valid_q  <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            multi_hot_q <= multi_hot_d;
            last_wr_a_q <= last_wr_a_d;
            wr_valid_q  <= wr_valid_d;
        end
    end

    assign bus.o_RD1      = read_port(bus.i_RA1);
    assign bus.o_RD2      = read_port(bus.i_RA2);
    assign bus.o_MultiHot = multi_hot_q;
    assign bus.o_LastWrA  = last_wr_a_q;
    assign bus.o_WrValid  = wr_valid_q;
endmodule

// File: tb/tb_reg_file_onehot_wr.sv
// Randomized bench for reg_file_onehot_wr against an array-based model of the register file.
module tb_reg_file_onehot_wr;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    reg_file_onehot_wr_if #(.N(32), .W(32)) bus();

    reg_file_onehot_wr #(.N(32), .W(32)) dut (
        .i_CLK  (clk),
        .i_RST_N(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] model [32];
    logic        m_multi;
    logic [4:0]  m_last;
    logic        m_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        m_multi = 1'b0;
        m_last  = 5'd0;
        m_valid = 1'b0;
    endtask

    function automatic int bit_index(input logic [31:0] v);
        int k;
        k = -1;
        for (int i = 0; i < 32; i++) if (v[i]) k = i;
        return k;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        int k;
        if (a == 5'd0) return 32'h0;
        k = bit_index(bus.i_WE);
`ifdef REGFILE_BYPASS_EN
        if ($countones(bus.i_WE) == 1 && k != 0 && k == int'(a)) return bus.i_D;
`endif
        return model[a];
    endfunction

    task automatic model_edge();
        int cnt;
        int k;
        cnt = $countones(bus.i_WE);
        k   = bit_index(bus.i_WE);
        m_valid = 1'b0;
        if (cnt >= 2) m_multi = 1'b1;
        else if (cnt == 1 && k != 0) begin
            model[k] = bus.i_D;
            m_last   = 5'(k);
            m_valid  = 1'b1;
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_wrvalid"}, 32'(bus.o_WrValid), 32'(m_valid));
        check({tag, "_lastwra"}, 32'(bus.o_LastWrA), 32'(m_last));
        check({tag, "_multihot"}, 32'(bus.o_MultiHot), 32'(m_multi));
    endtask

    task automatic cyc(input logic [31:0] we, input logic [31:0] d,
                       input logic [4:0] ra1, input logic [4:0] ra2);
        @(negedge clk);
        bus.i_WE  = we;
        bus.i_D   = d;
        bus.i_RA1 = ra1;
        bus.i_RA2 = ra2;
        #1;
        check("rd1_pre", bus.o_RD1, exp_rd(ra1));
        check("rd2_pre", bus.o_RD2, exp_rd(ra2));
        @(posedge clk);
        model_edge();
        #1;
        check_status("post");
        check("rd1_post", bus.o_RD1, exp_rd(ra1));
        check("rd2_post", bus.o_RD2, exp_rd(ra2));
    endtask

    function automatic logic [31:0] onehot(input int k);
        logic [31:0] v;
        v = 32'h0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        bus.i_WE = 32'h0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_rd1", bus.o_RD1, 32'h0);
        check_status("rst");
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] we;
        int a, b, kind;
        model_reset();
        bus.i_WE = 32'h0;  bus.i_D = 32'h0;
        bus.i_RA1 = 5'd0;  bus.i_RA2 = 5'd0;
        #1;
        check_status("init");
        check("init_rd1", bus.o_RD1, 32'h0);
        #20 rst_n = 1'b1;

        // Reset mid-cycle clears a written register immediately
        cyc(onehot(5), 32'hDEADBEEF, 5'd5, 5'd5);
        @(negedge clk);
        bus.i_WE = 32'h0;  bus.i_RA1 = 5'd5;
        #1 check("pre_rst_rd1", bus.o_RD1, 32'hDEADBEEF);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_rd1", bus.o_RD1, 32'h0);
        check_status("mid_rst");
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Single write, WrValid pulses one cycle
        cyc(32'h0000_0100, 32'h12345678, 5'd8, 5'd8);
        check("wv_one", 32'(bus.o_WrValid), 32'h1);
        cyc(32'h0, 32'h0, 5'd8, 5'd8);
        check("wv_drop", 32'(bus.o_WrValid), 32'h0);

        // Register 0 protection
        cyc(32'h1, 32'hFFFFFFFF, 5'd0, 5'd0);

        // Multi-hot rejection, sticky through ten legal writes
        cyc(onehot(3), 32'hA, 5'd3, 5'd4);
        cyc(onehot(4), 32'hB, 5'd3, 5'd4);
        cyc(32'h18, 32'h55, 5'd3, 5'd4);
        check("mh_set", 32'(bus.o_MultiHot), 32'h1);
        for (int i = 0; i < 10; i++)
            cyc(onehot($urandom_range(1, 31)), $urandom, 5'($urandom), 5'($urandom));
        check("mh_sticky", 32'(bus.o_MultiHot), 32'h1);
        do_reset();

        // Same-cycle read/write on reg 9
        cyc(onehot(9), 32'h1, 5'd9, 5'd9);
        cyc(onehot(9), 32'hCAFE, 5'd0, 5'd9);

        // Dual-port boundary and back-to-back writes
        cyc(onehot(31), 32'h7, 5'd31, 5'd31);
        cyc(32'h0, 32'h0, 5'd31, 5'd31);
        check("rd31_both", bus.o_RD1 ^ bus.o_RD2 ^ 32'h7, 32'h7);
        cyc(onehot(2), 32'h2222, 5'd2, 5'd30);
        cyc(onehot(30), 32'h3030, 5'd2, 5'd30);
        check("b2b_last", 32'(bus.o_LastWrA), 32'd30);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 500; n++) begin
            kind = int'($urandom_range(0, 7));
            if (kind == 0) we = 32'h0;
            else if (kind == 7) begin
                a  = int'($urandom_range(0, 31));
                b  = (a + 1 + int'($urandom_range(0, 30))) % 32;
                we = onehot(a) | onehot(b) | ($urandom & $urandom);
            end else we = onehot(int'($urandom_range(0, 31)));
            cyc(we, $urandom, 5'($urandom), 5'($urandom));
            if (n == 250) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/reg_file_onehot_wr.md
Name: reg_file_onehot_wr

Overview:
- General-purpose register file for the hardware-scheduled MIPS pipeline; sits directly downstream of the write-back address decoder.
- Write port takes the decoder's N-bit one-hot write-enable vector plus write data; two combinational read ports serve ID-stage operand fetch.
- Register 0 is hardwired to zero.
- Guards against malformed (multi-hot) enable vectors with a sticky error flag, and records the encoded index of the last accepted write for debug.

Parameters:
- N, 32, number of registers; power of two, >= 2
- W, 32, register data width

Ports:
- i_CLK  input  1  clock; all state updates on rising edge
- i_RST_N  input  1  asynchronous active-low reset
- i_WE  input  N  one-hot write-enable vector from the write-back decoder; all-zero = no write
- i_D  input  W  write data
- i_RA1  input  $clog2(N)  read address, port 1
- i_RA2  input  $clog2(N)  read address, port 2
- o_RD1  output  W  read data, port 1
- o_RD2  output  W  read data, port 2
- o_MultiHot  output  1  sticky error: a multi-hot i_WE was seen since reset
- o_LastWrA  output  $clog2(N)  encoded index of the most recent committed write
- o_WrValid  output  1  registered; high for one cycle after each committed write

Behaviour:
- Reset (i_RST_N low, asynchronous, takes effect immediately regardless of clock): all N registers = 0; o_MultiHot = 0; o_LastWrA = 0; o_WrValid = 0. Reads during reset return 0.
- Write classification, evaluated each rising edge on i_WE:
  - Zero bits set: no write. o_WrValid <= 0.
  - Exactly one bit k set, k != 0: reg[k] <= i_D; o_LastWrA <= k; o_WrValid <= 1.
  - Exactly bit 0 set: no-op, not an error. reg[0] stays 0; o_WrValid <= 0; o_LastWrA unchanged.
  - Two or more bits set (bit 0 counts): entire write dropped, no register changes. o_MultiHot <= 1; o_WrValid <= 0; o_LastWrA unchanged.
- o_MultiHot clears only on reset.
- Read ports are combinational from the address, zero latency. RAx == 0 always returns 0. Both ports may read the same address.
- A write becomes visible to reads after the rising edge that commits it; same-cycle behaviour is governed by the optional feature.
- Reset asserted in the same cycle as a valid write: reset wins, the register stays 0.
- Register storage: flops with asynchronous clear; no RAM inference required.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: if i_WE is a legal single-hot vector with bit k != 0 and RAx == k in the same cycle, o_RDx = i_D combinationally (write-before-read). Multi-hot, bit-0-only and zero vectors never bypass.
- Undefined: reads always return stored contents; the same-cycle read sees the old value.

Test Plan:
- Reset then read: assert i_RST_N=0 mid-cycle after reg[5] was written 0xDEADBEEF -> o_RD1 (RA1=5) = 0 immediately; o_MultiHot=0, o_LastWrA=0, o_WrValid=0.
- Single write: i_WE=32'h0000_0100, i_D=0x12345678, edge -> reg[8] = 0x12345678 on both ports; o_LastWrA=8; o_WrValid=1 for exactly one cycle.
- Register 0 protection: i_WE=32'h1, i_D=0xFFFFFFFF -> RA1=0 reads 0; o_WrValid=0; o_MultiHot=0.
- Multi-hot rejection: reg[3]=0xA, reg[4]=0xB, then i_WE=32'h18, i_D=0x55 -> reg[3]=0xA and reg[4]=0xB unchanged; o_MultiHot=1 and stays 1 through 10 further legal writes until reset.
- Same-cycle read/write: RA2=9, i_WE bit 9 set, i_D=0xCAFE, prior reg[9]=0x1 -> o_RD2=0xCAFE before the edge with REGFILE_BYPASS_EN defined, 0x1 without; 0xCAFE after the edge in both builds.
- Dual-port and boundary: write reg[31]=0x7; RA1=RA2=31 -> both ports read 0x7. Back-to-back writes to reg[2] then reg[30] -> o_LastWrA=2 then 30; o_WrValid high for both cycles.
